prefetch_read_scheduler: RTL and testbench
==========================================

Name: prefetch_read_scheduler

Overview:
- Shares one AXI4 read-address/read-data channel between NUM_REQ prefetch buffers.
- Each buffer streams a contiguous node array of 32-bit words, starting at its own base address, over a prefetch_req / grant / data_valid / data_ready interface.
- Arbitration is round-robin, one burst at a time. Each burst is sized from the node words still to fetch and clipped at 4 KB boundaries.
- Sits between the prefetch buffers and the AXI interconnect. Also tracks per-requester fetch progress and completion.

Parameters:
NUM_REQ, 2, number of prefetch buffers served (2..4)
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, word width; fixed at 32 (arsize = 3'b010)
MAX_BURST, 16, maximum beats per burst (1..256); buffers must satisfy threshold + MAX_BURST <= depth

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  pulse: clear all fetch counters, done and err flags
base_addr  in  NUM_REQ*ADDR_WIDTH  per-requester word-aligned base address, slice i = requester i
total_nodes  in  NUM_REQ*16  per-requester word count to fetch
pf_req  in  NUM_REQ  requester wants data
pf_grant  out  NUM_REQ  one-hot, high for the entire burst owned by requester i
pf_data  out  DATA_WIDTH  shared read-data bus (= rdata)
pf_valid  out  NUM_REQ  one-hot beat valid to the owner
pf_ready  in  NUM_REQ  owner can accept a beat
m_araddr  out  ADDR_WIDTH  burst address
m_arlen  out  8  beats-1
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_arvalid  out  1  address valid
m_arready  in  1  address accepted
m_rdata  in  DATA_WIDTH  read data
m_rresp  in  2  read response
m_rlast  in  1  last beat
m_rvalid  in  1  data valid
m_rready  out  1  data accept
done  out  NUM_REQ  fetched_i == total_nodes_i
err  out  NUM_REQ  sticky: non-OKAY rresp seen in a burst owned by requester i
busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; all outputs 0 except m_arsize and m_arburst (constants).
  - fetched counters = 0; round-robin pointer = 0.
- Eligibility: requester i is eligible when pf_req[i] && !done[i] && total_nodes_i != 0.
- FSM states:
  - IDLE:
    - If any requester is eligible, pick the first eligible index at or after rr_ptr (modulo NUM_REQ) and latch it as owner.
    - Compute addr = base_i + 4*fetched_i (ADDR_WIDTH, wraps silently).
    - Compute beats = min(MAX_BURST, total_i - fetched_i, (4096 - addr[11:0]) >> 2).
    - Set m_araddr and m_arlen = beats-1, assert pf_grant[owner], go to ADDR.
    - The decision is registered: m_arvalid rises exactly 1 cycle after IDLE sees the eligible request.
  - ADDR:
    - m_arvalid = 1; araddr and arlen are held stable until m_arready.
    - On handshake: fetched_owner += beats; rr_ptr = owner+1 mod NUM_REQ; go to DATA.
  - DATA:
    - m_rready = pf_ready[owner].
    - pf_valid[owner] = m_rvalid; pf_data = m_rdata combinationally (zero added latency).
    - Each beat with rresp != 0 sets err[owner]; the beat is still forwarded.
    - On m_rvalid && m_rready && m_rlast: drop pf_grant, go to IDLE.
    - rlast arriving on a different beat count than arlen+1 also sets err[owner]; the burst ends on rlast regardless.
- Only one burst is outstanding at any time; no new AR is issued until rlast.
- done[i] is combinational from the counter compare. Raising total_nodes later re-enables the requester.
- start:
  - In IDLE: clears counters, done, err and rr_ptr next cycle.
  - Outside IDLE: deferred; applied on the return to IDLE, and that cycle issues no new grant.
- pf_req deasserted mid-burst is ignored; the burst completes.
- Simultaneous requests: the round-robin pointer guarantees each eligible requester is granted within NUM_REQ bursts.
- 16-bit remaining arithmetic; beats are always >= 1 whenever a requester is eligible.
- Reset asserted mid-burst returns everything to reset values immediately. The AXI slave side is assumed reset by the same rst_n.

Test Plan:
- Single requester: base 0x1000, total 40, MAX_BURST 16, ready=1 → three ARs: 0x1000/arlen 15, 0x1040/15, 0x1080/7; 40 beats forwarded in order; done[0]=1; no further AR.
- 4 KB clip: base 0x1FF0, total 16 → AR 0x1FF0 arlen 3, then AR 0x2000 arlen 11.
- Both requesters hold pf_req continuously, total 64 each → grants alternate 0,1,0,1…; 4 bursts each; both done.
- Backpressure: owner pf_ready toggles every cycle, m_rvalid held → m_rready mirrors pf_ready; no beat lost or duplicated; arvalid held 5 cycles with arready low keeps araddr/arlen stable.
- rresp = 2'b10 on beat 3 of a requester-1 burst → err[1]=1 stays set; burst completes; next burst issues normally; start pulse clears err and done.
- Assert rst_n low during DATA at beat 5 → pf_grant, m_rready, busy all 0 asynchronously; after release, fetched=0 and the first AR returns to base_addr.

Source files
------------

// File: rtl/prefetch_read_scheduler.sv
`default_nettype none
// prefetch_read_scheduler: round-robin AXI4 read-burst scheduler for NUM_REQ prefetch buffers.
// Bursts are sized from the remaining words and clipped at 4 KB boundaries; one burst in flight.
module prefetch_read_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_REQ*16-1:0]         total_nodes,
  input  logic [NUM_REQ-1:0]            pf_req,
  output logic [NUM_REQ-1:0]            pf_grant,
  output logic [DATA_WIDTH-1:0]         pf_data,
  output logic [NUM_REQ-1:0]            pf_valid,
  input  logic [NUM_REQ-1:0]            pf_ready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic                          busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]      owner, rr_ptr, pick;
  logic                  found;
  logic [15:0]           fetched [NUM_REQ];
  logic [8:0]            beat_cnt;
  logic                  start_pend, start_now;
  logic                  ar_fire, r_fire;
  logic [NUM_REQ-1:0]    eligible, owner_oh;
  logic [ADDR_WIDTH-1:0] base_sel, pick_addr;
  logic [15:0]           fetched_sel, total_sel, pick_remain;
  logic [10:0]           page_words;
  logic [8:0]            pick_beats;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign done[i]     = (fetched[i] == total_nodes[i*16 +: 16]);
    assign eligible[i] = pf_req[i] && !done[i] && (total_nodes[i*16 +: 16] != 16'd0);
    assign owner_oh[i] = (owner == IDX_W'(i));
  end

  // Lowest eligible index overall, overridden by the lowest one at or after rr_ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i] && (i >= int'(rr_ptr))) pick = IDX_W'(i);
    end
  end

  always_comb begin
    base_sel    = '0;
    fetched_sel = '0;
    total_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        base_sel    = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        fetched_sel = fetched[i];
        total_sel   = total_nodes[i*16 +: 16];
      end
    end
    pick_addr   = base_sel + ADDR_WIDTH'({fetched_sel, 2'b00});
    pick_remain = total_sel - fetched_sel;
    page_words  = 11'd1024 - {1'b0, pick_addr[11:2]};
    pick_beats  = 9'(MAX_BURST);
    if (pick_remain < 16'(pick_beats)) pick_beats = pick_remain[8:0];
    if (page_words < 11'(pick_beats))  pick_beats = page_words[8:0];
  end

  assign start_now = (state == IDLE) && (start || start_pend);
  assign ar_fire   = (state == ADDR) && m_arready;
  assign r_fire    = (state == DATA) && m_rvalid && m_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    pf_grant  = '0;
    pf_valid  = '0;
    case (state)
      IDLE: if (!start_now && found) state_nxt = ADDR;
      ADDR: begin
        m_arvalid = 1'b1;
        pf_grant  = owner_oh;
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        pf_grant = owner_oh;
        m_rready = |(pf_ready & owner_oh);
        pf_valid = owner_oh & {NUM_REQ{m_rvalid}};
        if (m_rvalid && m_rready && m_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      rr_ptr     <= '0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      beat_cnt   <= '0;
      err        <= '0;
      start_pend <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) fetched[i] <= '0;
    end else begin
      if (start && (state != IDLE)) start_pend <= 1'b1;
      if (state == IDLE) begin
        if (start_now) begin
          start_pend <= 1'b0;
          rr_ptr     <= '0;
          err        <= '0;
          for (int i = 0; i < NUM_REQ; i++) fetched[i] <= '0;
        end else if (found) begin
          owner    <= pick;
          m_araddr <= pick_addr;
          m_arlen  <= 8'(pick_beats - 9'd1);
        end
      end
      if (ar_fire) begin
        beat_cnt <= '0;
        rr_ptr   <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + IDX_W'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_oh[i]) fetched[i] <= fetched[i] + {8'd0, m_arlen} + 16'd1;
        end
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + 9'd1;
        // A bad response or an rlast on the wrong beat both flag the owner.
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_oh[i] && ((m_rresp != 2'b00) || (m_rlast && (beat_cnt != {1'b0, m_arlen}))))
            err[i] <= 1'b1;
        end
      end
    end
  end

  assign pf_data   = m_rdata;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_prefetch_read_scheduler.sv
`default_nettype none
// tb_prefetch_read_scheduler: directed self-checking bench with an inline AXI read-slave driver.
module tb_prefetch_read_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, start, m_arready, m_rlast, m_rvalid;
  logic [31:0] b0, b1, m_rdata, dval;
  logic [15:0] t0, t1;
  logic [1:0]  pf_req, pf_ready, m_rresp;
  logic [63:0] base_addr;
  logic [31:0] total_nodes;
  logic [1:0]  pf_grant, pf_valid, done, err;
  logic [31:0] pf_data, m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_rready, busy;
  int          tests = 0;
  int          fails = 0;

  assign base_addr   = {b1, b0};
  assign total_nodes = {t1, t0};

  always #5 clk = ~clk;

  prefetch_read_scheduler #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .total_nodes(total_nodes),
    .pf_req(pf_req), .pf_grant(pf_grant), .pf_data(pf_data), .pf_valid(pf_valid),
    .pf_ready(pf_ready), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .done(done), .err(err), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Wait for an AR, check it, optionally stall arready for 'hold' cycles, then accept it.
  task automatic expect_ar(input int own, input logic [31:0] addr, input logic [7:0] len, input int hold);
    int cyc = 0;
    while (!m_arvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("arvalid", m_arvalid, 1);
    check("araddr", m_araddr, addr);
    check("arlen", m_arlen, len);
    check("ar_grant", pf_grant, 64'(1) << own);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("arvalid_hold", m_arvalid, 1);
      check("araddr_hold", m_araddr, addr);
      check("arlen_hold", m_arlen, len);
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    check("arvalid_drop", m_arvalid, 0);
  endtask

  // Drive n beats; pf_ready of the owner toggles when requested, rvalid stays high.
  task automatic send_beats(input int own, input int n, input bit with_last, input int err_idx, input bit toggle);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < 200) begin
      m_rvalid = 1'b1;
      m_rdata  = dval;
      m_rresp  = (sent == err_idx) ? 2'b10 : 2'b00;
      m_rlast  = with_last && (sent == n - 1);
      pf_ready[own] = toggle ? cyc[0] : 1'b1;
      #1;
      check("rready", m_rready, toggle ? cyc[0] : 1'b1);
      check("pf_valid", pf_valid, 64'(1) << own);
      check("pf_data", pf_data, dval);
      @(posedge clk);
      if (pf_ready[own]) begin
        sent++;
        dval++;
      end
      @(negedge clk);
      cyc++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
    pf_ready = 2'b11;
    if (sent < n) check("beat_timeout", sent, n);
    if (with_last) check("grant_drop", pf_grant, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; m_arready = 1'b0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0; m_rresp = '0; pf_req = '0; pf_ready = 2'b11; dval = 32'hA000_0000;
    b0 = 32'h1000; t0 = 16'd40; b1 = 32'h1FF0; t1 = 16'd16;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", pf_grant, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arsize", m_arsize, 3'b010);
    check("rst_arburst", m_arburst, 2'b01);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 40 words in bursts of 16/16/8.
    pf_req = 2'b01;
    #1 check("ar_latency_0", m_arvalid, 0);
    @(negedge clk);
    check("ar_latency_1", m_arvalid, 1);
    expect_ar(0, 32'h1000, 8'd15, 0); send_beats(0, 16, 1, -1, 0);
    expect_ar(0, 32'h1040, 8'd15, 0); send_beats(0, 16, 1, -1, 0);
    expect_ar(0, 32'h1080, 8'd7, 0);  send_beats(0, 8, 1, -1, 0);
    check("single_done", done, 2'b01);
    repeat (4) @(negedge clk);
    check("single_no_ar", m_arvalid, 0);
    check("single_idle", busy, 0);

    // 4 KB clip on requester 1.
    pf_req = 2'b10;
    expect_ar(1, 32'h1FF0, 8'd3, 0);  send_beats(1, 4, 1, -1, 0);
    expect_ar(1, 32'h2000, 8'd11, 0); send_beats(1, 12, 1, -1, 0);
    check("clip_done", done, 2'b11);

    // Both requesting: alternating grants, with AR stall and data backpressure.
    pf_req = 2'b00; b0 = 32'h0; b1 = 32'h8000; t0 = 16'd64; t1 = 16'd64;
    pulse_start();
    check("start_done_clr", done, 2'b00);
    pf_req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      expect_ar(k % 2, ((k % 2) ? 32'h8000 : 32'h0) + 32'((k / 2) * 64), 8'd15, (k == 2) ? 5 : 0);
      send_beats(k % 2, 16, 1, -1, k == 3);
    end
    check("rr_done", done, 2'b11);
    check("rr_err", err, 2'b00);

    // Error response on beat 3 of a requester-1 burst.
    pf_req = 2'b00; b1 = 32'h3000; t1 = 16'd32;
    pulse_start();
    pf_req = 2'b10;
    expect_ar(1, 32'h3000, 8'd15, 0); send_beats(1, 16, 1, 2, 0);
    check("err_set", err, 2'b10);
    expect_ar(1, 32'h3040, 8'd15, 0); send_beats(1, 16, 1, -1, 0);
    check("err_sticky", err, 2'b10);
    check("err_done", done, 2'b10);
    pf_req = 2'b00;
    pulse_start();
    check("start_err_clr", err, 2'b00);
    check("start_done_clr2", done, 2'b00);

    // Reset during the data phase after 5 beats.
    pf_req = 2'b01;
    expect_ar(0, 32'h0, 8'd15, 0); send_beats(0, 5, 0, -1, 0);
    check("pre_rst_rready", m_rready, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", pf_grant, 0);
    check("mid_rst_rready", m_rready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_ar(0, 32'h0, 8'd15, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
